// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the ALU slice. Holds the default
//               datapath width and the 2-bit operation-select encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Default operand/result width in bits
    localparam int DEFAULT_WIDTH = 64;

    // Operation-select encodings carried on the control input
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_add_sub_64.sv
`default_nettype none
// ============================================================================
// Module      : add_sub_64
// Description : Ripple-carry adder/subtractor built from full-adder cells.
//               With sub=1 operand b is inverted and the carry-in is forced
//               to 1, giving a - b in two's complement through the same chain.
// Ports       : a, b      - operands (WIDTH bits)
//               sub       - 0: a + b, 1: a - b
//               sum       - result modulo 2^WIDTH
//               overflow  - signed overflow of the operation
// Revision    : 1.0 - initial release
// ============================================================================
module add_sub_64
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             overflow
);

    logic [WIDTH-1:0] w_b_eff;

    assign w_b_eff = b ^ {WIDTH{sub}};

    // Each cell keeps its own carry nets so the chain is expressed as a
    // cell-to-cell connection rather than a self-referencing vector.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_fa
            logic w_cin;
            logic w_cout;
            if (i == 0) begin : g_lsb
                assign w_cin = sub;
            end else begin : g_chain
                assign w_cin = g_fa[i-1].w_cout;
            end
            assign sum[i] = a[i] ^ w_b_eff[i] ^ w_cin;
            assign w_cout = (a[i] & w_b_eff[i]) | (w_cin & (a[i] ^ w_b_eff[i]));
        end
    endgenerate

    // Signed overflow: carry into the sign bit differs from carry out of it.
    // The unsigned carry-out itself is not exported.
    assign overflow = g_fa[WIDTH-1].w_cin ^ g_fa[WIDTH-1].w_cout;

endmodule : add_sub_64
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : Registered 4-function ALU (ADD, SUB, AND, XOR) with a signed
//               overflow flag. One operation accepted per cycle; result is
//               visible after the rising edge that samples the inputs.
// Ports       : clk      - clock, rising-edge active
//               rst      - asynchronous active-high reset, clears out and c
//               control  - operation select (see alu_pkg)
//               a, b     - two's-complement operands
//               out      - registered result
//               c        - registered signed-overflow flag (0 for AND/XOR)
// Revision    : 1.0 - initial release
// ============================================================================
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             c
);

    logic             w_sub;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;
    logic [WIDTH-1:0] w_result;
    logic             w_flag;
    logic [WIDTH-1:0] r_out;
    logic             r_c;

    assign w_sub = (control == ALU_SUB);

    add_sub_64 #(
        .WIDTH    (WIDTH)
    ) u_add_sub (
        .a        (a),
        .b        (b),
        .sub      (w_sub),
        .sum      (w_sum),
        .overflow (w_ovf)
    );

    // Result and overflow selection; logical ops never flag overflow.
    always_comb begin
        w_result = w_sum;
        w_flag   = 1'b0;
        case (control)
            ALU_ADD: begin
                w_result = w_sum;
                w_flag   = w_ovf;
            end
            ALU_SUB: begin
                w_result = w_sum;
                w_flag   = w_ovf;
            end
            ALU_AND: w_result = a & b;
            ALU_XOR: w_result = a ^ b;
            default: begin
                w_result = w_sum;
                w_flag   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= '0;
            r_c   <= 1'b0;
        end else begin
            r_out <= w_result;
            r_c   <= w_flag;
        end
    end

    assign out = r_out;
    assign c   = r_c;

endmodule : alu
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu
// Description : Self-checking bench for alu. Each scenario task drives
//               operations, pushes the expected result to a scoreboard queue
//               and pops/compares once the DUT has registered the operation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct packed {
        logic [63:0] out;
        logic        c;
    } exp_t;

    typedef struct packed {
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] out;
        logic        c;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [1:0]  control;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] out;
    logic        c;

    exp_t sb[$];
    int   vectors;
    int   miscompares;

    alu #(.WIDTH(64)) dut (
        .clk     (clk),
        .rst     (rst),
        .control (control),
        .a       (a),
        .b       (b),
        .out     (out),
        .c       (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: arithmetic done at 65 bits, signed overflow detected
    // as the result falling outside the 64-bit signed range.
    function automatic exp_t model(input logic [1:0] op, input logic [63:0] x, input logic [63:0] y);
        exp_t r;
        logic signed [64:0] wide;
        r.out = '0;
        r.c   = 1'b0;
        case (op)
            OP_ADD: begin
                wide  = $signed({x[63], x}) + $signed({y[63], y});
                r.out = wide[63:0];
                r.c   = (wide > $signed({1'b0, MAXP})) || (wide < $signed({1'b1, MINN}));
            end
            OP_SUB: begin
                wide  = $signed({x[63], x}) - $signed({y[63], y});
                r.out = wide[63:0];
                r.c   = (wide > $signed({1'b0, MAXP})) || (wide < $signed({1'b1, MINN}));
            end
            OP_AND: r.out = x & y;
            default: r.out = x ^ y;
        endcase
        return r;
    endfunction

    // Drive one operation at the falling edge and record its expectation.
    task automatic drive(input logic [1:0] op, input logic [63:0] x, input logic [63:0] y);
        @(negedge clk);
        control = op;
        a       = x;
        b       = y;
        sb.push_back(model(op, x, y));
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1; control = OP_ADD; a = 64'd5; b = 64'd6;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (out !== 64'd0 || c !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: out=%h c=%b, required out=0 c=0", out, c);
        end
        // First edge after release registers whatever is on the inputs
        @(negedge clk);
        rst = 1'b0;
        sb.push_back(model(OP_ADD, 64'd5, 64'd6));
        @(posedge clk); #1;
        e = sb.pop_front();
        vectors++;
        if (out !== e.out || c !== e.c || e.out !== 64'd11) begin
            miscompares++;
            $display("FAIL reset_release: out=%h c=%b, required out=%h c=%b", out, c, 64'd11, 1'b0);
        end
    endtask

    task automatic test_directed();
        vec_t tbl[12];
        exp_t e;
        tbl[0]  = '{OP_SUB, 64'd62, 64'd63, ONES, 1'b0};
        tbl[1]  = '{OP_SUB, 64'd63, 64'd56, 64'd7, 1'b0};
        tbl[2]  = '{OP_ADD, MAXP, 64'd1, MINN, 1'b1};
        tbl[3]  = '{OP_SUB, MINN, 64'd1, MAXP, 1'b1};
        tbl[4]  = '{OP_AND, 64'd63, 64'd56, 64'd56, 1'b0};
        tbl[5]  = '{OP_XOR, 64'd63, 64'd55, 64'd8, 1'b0};
        tbl[6]  = '{OP_SUB, 64'd0, 64'd1, ONES, 1'b0};
        tbl[7]  = '{OP_ADD, ONES, 64'd1, 64'd0, 1'b0};
        tbl[8]  = '{OP_SUB, 64'd0, MINN, MINN, 1'b1};
        tbl[9]  = '{OP_SUB, 64'd5, MINN, 64'h8000_0000_0000_0005, 1'b1};
        tbl[10] = '{OP_ADD, MINN, MINN, 64'd0, 1'b1};
        tbl[11] = '{OP_AND, ONES, MINN, MINN, 1'b0};
        foreach (tbl[i]) begin
            drive(tbl[i].op, tbl[i].a, tbl[i].b);
            @(posedge clk); #1;
            e = sb.pop_front();
            vectors++;
            // Table constants are the hand-derived answers; the model must agree too
            if (out !== tbl[i].out || c !== tbl[i].c || e.out !== tbl[i].out || e.c !== tbl[i].c) begin
                miscompares++;
                $display("FAIL directed[%0d]: out=%h c=%b, required out=%h c=%b",
                         i, out, c, tbl[i].out, tbl[i].c);
            end
        end
    endtask

    // Full sweep, one new operation every cycle with no idle cycles between
    task automatic test_back_to_back();
        exp_t e;
        for (int op = 0; op < 4; op++) begin
            for (int x = 55; x <= 62; x++) begin
                for (int y = 56; y <= 63; y++) begin
                    drive(op[1:0], 64'(x), 64'(y));
                    @(posedge clk); #1;
                    e = sb.pop_front();
                    vectors++;
                    if (out !== e.out || c !== e.c) begin
                        miscompares++;
                        $display("FAIL sweep op=%0d a=%0d b=%0d: out=%h c=%b, required out=%h c=%b",
                                 op, x, y, out, c, e.out, e.c);
                    end
                end
            end
        end
        // Random operands across the full range, still back-to-back
        for (int i = 0; i < 200; i++) begin
            drive(2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom});
            @(posedge clk); #1;
            e = sb.pop_front();
            vectors++;
            if (out !== e.out || c !== e.c) begin
                miscompares++;
                $display("FAIL random[%0d]: out=%h c=%b, required out=%h c=%b", i, out, c, e.out, e.c);
            end
        end
    endtask

    task automatic test_hold();
        exp_t e;
        drive(OP_ADD, 64'd5, 64'd3);
        @(posedge clk); #1;
        e = sb.pop_front();
        #1;
        a = 64'd100;   // change between edges
        #2;
        vectors++;
        if (out !== 64'd8 || e.out !== 64'd8) begin
            miscompares++;
            $display("FAIL hold_between_edges: out=%h, required out=%h", out, 64'd8);
        end
        sb.push_back(model(OP_ADD, 64'd100, 64'd3));
        @(posedge clk); #1;
        e = sb.pop_front();
        vectors++;
        if (out !== e.out || out !== 64'd103) begin
            miscompares++;
            $display("FAIL hold_next_edge: out=%h, required out=%h", out, 64'd103);
        end
    endtask

    task automatic test_reset_midstream();
        exp_t e;
        drive(OP_XOR, 64'hDEAD, 64'h0);
        @(posedge clk); #1;
        e = sb.pop_front();
        vectors++;
        if (out !== e.out) begin
            miscompares++;
            $display("FAIL pre_reset: out=%h, required out=%h", out, e.out);
        end
        // ADD 63+63 pending, then reset before it is captured
        @(negedge clk);
        control = OP_ADD; a = 64'd63; b = 64'd63;
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (out !== 64'd0 || c !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async: out=%h c=%b, required out=0 c=0", out, c);
        end
        @(posedge clk); #1;
        vectors++;
        if (out !== 64'd0 || c !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_discard: out=%h c=%b, required out=0 c=0", out, c);
        end
        @(negedge clk);
        rst = 1'b0;
        sb.push_back(model(OP_ADD, 64'd63, 64'd63));
        @(posedge clk); #1;
        e = sb.pop_front();
        vectors++;
        if (out !== 64'd126 || c !== 1'b0 || e.out !== 64'd126) begin
            miscompares++;
            $display("FAIL reset_resume: out=%h c=%b, required out=%h c=0", out, c, 64'd126);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_hold();
        test_reset_midstream();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule : tb_alu
`default_nettype wire

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter: WIDTH, default 64, operand and result width in bits; all REQs below use WIDTH=64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 control  input  2  operation select: 00 ADD, 01 SUB, 10 AND, 11 XOR.
REQ-005 a  input  64  first operand, two's-complement.
REQ-006 b  input  64  second operand, two's-complement.
REQ-007 out  output  64  registered result.
REQ-008 c  output  1  registered signed-overflow flag.

Function
REQ-009 ADD (00) SHALL compute out = (a + b) mod 2^64.
REQ-010 SUB (01) SHALL compute out = (a - b) mod 2^64, implemented as a + ~b + 1 through the same adder.
REQ-011 AND (10) SHALL compute out = a & b bitwise.
REQ-012 XOR (11) SHALL compute out = a ^ b bitwise.
REQ-013 ADD: c SHALL be 1 iff a[63]==b[63] and sum[63]!=a[63].
REQ-014 SUB: c SHALL be 1 iff a[63]!=b[63] and diff[63]!=a[63].
REQ-015 AND/XOR: c SHALL be 0.
REQ-016 Unsigned carry-out SHALL NOT affect c; it is discarded.
REQ-017 Latency: out and c SHALL reflect control/a/b sampled at rising edge N, visible after that edge, held until edge N+1.
REQ-018 No handshake: a new operation SHALL be accepted every cycle, throughput 1 op/cycle.
REQ-019 Input changes between edges SHALL NOT affect out/c until the next rising edge.
REQ-020 Boundaries: 0x7FFF_FFFF_FFFF_FFFF + 1 -> 0x8000_0000_0000_0000, c=1; 0x8000_0000_0000_0000 - 1 -> 0x7FFF_FFFF_FFFF_FFFF, c=1; 0 - 1 -> all ones, c=0; all-ones + 1 -> 0, c=0.
REQ-021 SUB with b = 0x8000_0000_0000_0000 and a >= 0 SHALL set c=1.

Reset
REQ-022 While rst=1, out SHALL be 0 and c SHALL be 0, immediately and independent of clk.
REQ-023 Assertion of rst mid-operation SHALL discard the in-flight result; no partial result appears.
REQ-024 First rising edge with rst=0 SHALL register the operation then present on inputs.

Structure
REQ-025 Shared package SHALL hold WIDTH default and opcode constants ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_XOR=2'b11.
REQ-026 Adder SHALL be a separate sub-module add_sub_64: 64-bit ripple-carry of full-adder cells with sub input (inverts b, carry-in 1), outputs sum and overflow.
REQ-027 alu top SHALL contain the AND/XOR bitwise logic, 4:1 result mux, overflow mux, and output register.

Verification
REQ-028 rst=1 mid-stream with a=b=63, ADD pending -> out=0, c=0 immediately; after release, next edge out=126, c=0.
REQ-029 SUB a=62, b=63 -> next edge out=0xFFFF_FFFF_FFFF_FFFF, c=0; SUB a=63, b=56 -> out=7, c=0.
REQ-030 ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> out=0x8000_0000_0000_0000, c=1; SUB a=0x8000_0000_0000_0000, b=1 -> out=0x7FFF_FFFF_FFFF_FFFF, c=1.
REQ-031 AND a=63, b=56 -> out=56, c=0; XOR a=63, b=55 -> out=8, c=0.
REQ-032 Sweep all 4 controls x a in 55..62 x b in 56..63, one op per cycle -> each result matches REQ-009..015 one cycle later, no bubbles.
REQ-033 Change a between edges -> out unchanged until next rising edge.
